// File: rtl/ones_burst_pkg.sv
// Shared types and constants for the ones_burst_tx serial burst transmitter.
package ones_burst_pkg;

  // Transmitter phases. The 2-bit encoding is fixed so that other blocks can decode it.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ONES = 2'b01,
    TERM = 2'b10,
    GAP  = 2'b11
  } state_e;

  // Width of the optional completed-frame counter.
  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/ones_burst_cnt.sv
// Loadable down-counter shared by the ONES and GAP phases of ones_burst_tx.
// It saturates at zero rather than wrapping, and flags when it holds exactly 1.
module ones_burst_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load has priority over decrement; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ones_burst_tx.sv
// Serial burst transmitter: sends len ones, a single zero terminator (done pulse),
// then GAP_LEN low guard cycles before accepting the next frame.
// Optional feature: define ONES_BURST_TX_COUNT_EN to add the 16-bit frame_cnt
// output, which counts every completed frame (including len=0 frames).
module ones_burst_tx
  import ones_burst_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int GAP_LEN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             ready,
  output logic             x_out,
  output logic             done
`ifdef ONES_BURST_TX_COUNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

  state_e           state_q;
  logic             x_out_q;
  logic             ready_q;
  logic             done_q;

  logic             cnt_load_d;
  logic [CNT_W-1:0] cnt_load_val_d;
  logic             cnt_dec_d;
  logic             cnt_last;

  // Counter control: capture len on a non-empty frame, reload with the gap length
  // in TERM, and count down through the ONES and GAP phases.
  always_comb begin
    cnt_load_d     = 1'b0;
    cnt_load_val_d = len;
    cnt_dec_d      = 1'b0;
    case (state_q)
      IDLE: cnt_load_d = start && (len != '0);
      ONES: cnt_dec_d  = 1'b1;
      TERM: begin
        cnt_load_d     = 1'b1;
        cnt_load_val_d = CNT_W'(GAP_LEN);
      end
      GAP:  cnt_dec_d  = 1'b1;
      default: begin
        cnt_load_d = 1'b0;
        cnt_dec_d  = 1'b0;
      end
    endcase
  end

  ones_burst_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (reset),
    .load_i    (cnt_load_d),
    .load_val_i(cnt_load_val_d),
    .dec_i     (cnt_dec_d),
    .last_o    (cnt_last)
  );

  // Frame sequencer with registered outputs: each output is set to the value of the
  // state being entered, so the line changes cleanly on the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      x_out_q <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            ready_q <= 1'b0;
            if (len != '0) begin
              state_q <= ONES;
              x_out_q <= 1'b1;
            end else begin
              // Terminator-only frame: line stays low, done still pulses.
              state_q <= TERM;
              done_q  <= 1'b1;
            end
          end
        end
        ONES: begin
          if (cnt_last) begin
            state_q <= TERM;
            x_out_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        TERM: begin
          state_q <= GAP;
        end
        GAP: begin
          if (cnt_last) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          x_out_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign x_out = x_out_q;
  assign done  = done_q;

`ifdef ONES_BURST_TX_COUNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  // Completed-frame count, bumped on the edge that leaves TERM; wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_q <= '0;
    end else if (state_q == TERM) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule
